// File: rtl/borders_pkg.sv
// Shared types and constants for the border layer: side encoding, flash FSM
// states, default colours and the pixel coordinate width.
package borders_pkg;

   localparam int         COORD_W          = 11;
   localparam logic [7:0] BORDER_COLOR_DEF = 8'h92;
   localparam logic [7:0] FLASH_COLOR_DEF  = 8'hE0;
   localparam logic [7:0] COLOR_STEP       = 8'h25;

   typedef enum logic [1:0] {
      SIDE_TOP    = 2'd0,
      SIDE_LEFT   = 2'd1,
      SIDE_RIGHT  = 2'd2,
      SIDE_BOTTOM = 2'd3
   } side_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FLASH = 1'b1
   } flash_state_t;

endpackage

// File: rtl/border_flash_timer.sv
// Frame-timed flash controller: latches hit sides, counts frames down and
// blinks. flash_active bit n (side_t order) is 1 while side n shows the flash colour.
module border_flash_timer
   import borders_pkg::*;
#(
   parameter int FLASH_FRAMES = 16,
   parameter int BLINK_FRAMES = 4
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         start_of_frame,
   input  logic         hit_req,
   input  logic [1:0]   hit_side,
   output logic [3:0]   flash_active,
   output flash_state_t state
);

   localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);
   localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);

   logic [3:0] flash_mask;
   logic [7:0] flash_cnt;
   logic [5:0] blink_cnt;
   logic       blink_on;

   // A hit always takes precedence over a frame tick in the same cycle.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= IDLE;
         flash_mask <= 4'b0000;
         flash_cnt  <= 8'd0;
         blink_cnt  <= 6'd0;
         blink_on   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hit_req) begin
                  state      <= FLASH;
                  flash_mask <= 4'b0001 << hit_side;
                  flash_cnt  <= FLASH_LOAD;
                  blink_cnt  <= 6'd0;
                  blink_on   <= 1'b1;
               end
            end
            FLASH: begin
               if (hit_req) begin
                  flash_mask <= flash_mask | (4'b0001 << hit_side);
                  flash_cnt  <= FLASH_LOAD;
               end else if (start_of_frame) begin
                  flash_cnt <= flash_cnt - 8'd1;
                  if (blink_cnt == BLINK_LAST) begin
                     blink_cnt <= 6'd0;
                     blink_on  <= ~blink_on;
                  end else begin
                     blink_cnt <= blink_cnt + 6'd1;
                  end
                  if (flash_cnt == 8'd1) begin
                     state      <= IDLE;
                     flash_mask <= 4'b0000;
                     blink_cnt  <= 6'd0;
                     blink_on   <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign flash_active = flash_mask & {4{blink_on}};

endmodule

// File: rtl/borders_draw_gen.sv
// Border layer producer: registered region decode and per-side colour.
// Optional BORDER_COLOR_CYCLE_EN steps the base colour every 32 frames.
module borders_draw_gen
   import borders_pkg::*;
#(
   parameter int         SCREEN_W     = 640,
   parameter int         SCREEN_H     = 480,
   parameter int         THICK        = 8,
   parameter logic [7:0] BORDER_COLOR = BORDER_COLOR_DEF,
   parameter logic [7:0] FLASH_COLOR  = FLASH_COLOR_DEF,
   parameter int         FLASH_FRAMES = 16,
   parameter int         BLINK_FRAMES = 4
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic [COORD_W-1:0] pixelX,
   input  logic [COORD_W-1:0] pixelY,
   input  logic               startOfFrame,
   input  logic               hit_req,
   input  logic [1:0]         hit_side,
   output logic               top_DR,
   output logic               left_DR,
   output logic               right_DR,
   output logic               bottom_DR,
   output logic [7:0]         top_RGB,
   output logic [7:0]         left_RGB,
   output logic [7:0]         right_RGB,
   output logic [7:0]         bottom_RGB
);

   localparam logic [COORD_W-1:0] W_LIM  = COORD_W'(SCREEN_W);
   localparam logic [COORD_W-1:0] H_LIM  = COORD_W'(SCREEN_H);
   localparam logic [COORD_W-1:0] T_LIM  = COORD_W'(THICK);
   localparam logic [COORD_W-1:0] R_EDGE = COORD_W'(SCREEN_W - THICK);
   localparam logic [COORD_W-1:0] B_EDGE = COORD_W'(SCREEN_H - THICK);

   logic [3:0]   flash_active;
   logic [3:0]   flash_on;
   flash_state_t flash_state;
   logic         visible;
   logic [3:0]   region;
   logic [3:0]   dr_q;
   logic [7:0]   rgb_q [4];
   logic [7:0]   base_color;

   border_flash_timer #(
      .FLASH_FRAMES (FLASH_FRAMES),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_flash_timer (
      .clk            (clk),
      .resetN         (resetN),
      .start_of_frame (startOfFrame),
      .hit_req        (hit_req),
      .hit_side       (hit_side),
      .flash_active   (flash_active),
      .state          (flash_state)
   );

`ifdef BORDER_COLOR_CYCLE_EN
   logic [4:0] frame_cnt;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         frame_cnt  <= 5'd0;
         base_color <= BORDER_COLOR;
      end else if (startOfFrame) begin
         frame_cnt <= frame_cnt + 5'd1;
         if (frame_cnt == 5'd31) base_color <= base_color + COLOR_STEP;
      end
   end
`else
   assign base_color = BORDER_COLOR;
`endif

   // Flash mask only means something while the timer is in FLASH.
   assign flash_on = (flash_state == FLASH) ? flash_active : 4'b0000;

   always_comb begin
      visible             = (pixelX < W_LIM) && (pixelY < H_LIM);
      region              = 4'b0000;
      region[SIDE_TOP]    = visible && (pixelY < T_LIM);
      region[SIDE_LEFT]   = visible && (pixelX < T_LIM);
      region[SIDE_RIGHT]  = visible && (pixelX >= R_EDGE);
      region[SIDE_BOTTOM] = visible && (pixelY >= B_EDGE);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         dr_q <= 4'b0000;
         for (int i = 0; i < 4; i++) rgb_q[i] <= 8'h00;
      end else begin
         dr_q <= region;
         for (int i = 0; i < 4; i++)
            rgb_q[i] <= region[i] ? (flash_on[i] ? FLASH_COLOR : base_color) : 8'h00;
      end
   end

   assign top_DR     = dr_q[SIDE_TOP];
   assign left_DR    = dr_q[SIDE_LEFT];
   assign right_DR   = dr_q[SIDE_RIGHT];
   assign bottom_DR  = dr_q[SIDE_BOTTOM];
   assign top_RGB    = rgb_q[SIDE_TOP];
   assign left_RGB   = rgb_q[SIDE_LEFT];
   assign right_RGB  = rgb_q[SIDE_RIGHT];
   assign bottom_RGB = rgb_q[SIDE_BOTTOM];

endmodule

// File: tb/tb_borders_draw_gen.sv
// Self-checking bench for borders_draw_gen: frame-level behavioural model,
// per-cycle compare, literal scenario checks and randomized traffic.
module tb_borders_draw_gen;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic [10:0] pixelX = 11'd0;
   logic [10:0] pixelY = 11'd0;
   logic        startOfFrame = 1'b0;
   logic        hit_req = 1'b0;
   logic [1:0]  hit_side = 2'd0;
   logic        top_DR, left_DR, right_DR, bottom_DR;
   logic [7:0]  top_RGB, left_RGB, right_RGB, bottom_RGB;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   string side_name [4] = '{"top", "left", "right", "bottom"};

   always #5 clk = ~clk;

   borders_draw_gen dut (
      .clk          (clk),
      .resetN       (resetN),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .startOfFrame (startOfFrame),
      .hit_req      (hit_req),
      .hit_side     (hit_side),
      .top_DR       (top_DR),
      .left_DR      (left_DR),
      .right_DR     (right_DR),
      .bottom_DR    (bottom_DR),
      .top_RGB      (top_RGB),
      .left_RGB     (left_RGB),
      .right_RGB    (right_RGB),
      .bottom_RGB   (bottom_RGB)
   );

   logic [3:0] dut_dr;
   logic [7:0] dut_rgb [4];
   assign dut_dr     = {bottom_DR, right_DR, left_DR, top_DR};
   assign dut_rgb[0] = top_RGB;
   assign dut_rgb[1] = left_RGB;
   assign dut_rgb[2] = right_RGB;
   assign dut_rgb[3] = bottom_RGB;

   // ---------------- behavioural model (frame level) ----------------
   bit         m_active;
   logic [3:0] m_mask;
   int         m_left;
   int         m_elapsed;
   int         m_sof_total;
   logic [3:0] exp_dr;
   logic [7:0] exp_rgb [4];

   function automatic bit in_region(int s, int x, int y);
      bit vis;
      vis = (x < 640) && (y < 480);
      case (s)
         0:       return vis && (y < 8);
         1:       return vis && (x < 8);
         2:       return vis && (x >= 632);
         default: return vis && (y >= 472);
      endcase
   endfunction

   function automatic logic [7:0] model_base(int sof_total);
`ifdef BORDER_COLOR_CYCLE_EN
      return 8'h92 + 8'((sof_total / 32) * 37);
`else
      return 8'h92 + 8'(sof_total * 0);
`endif
   endfunction

   function automatic bit model_blink(bit active, int elapsed);
      return active && (((elapsed / 4) % 2) == 0);
   endfunction

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_active    <= 1'b0;
         m_mask      <= 4'b0;
         m_left      <= 0;
         m_elapsed   <= 0;
         m_sof_total <= 0;
         exp_dr      <= 4'b0;
         for (int s = 0; s < 4; s++) exp_rgb[s] <= 8'h00;
      end else begin
         for (int s = 0; s < 4; s++) begin
            exp_dr[s]  <= in_region(s, int'(pixelX), int'(pixelY));
            exp_rgb[s] <= !in_region(s, int'(pixelX), int'(pixelY)) ? 8'h00 :
                          (m_mask[s] && model_blink(m_active, m_elapsed)) ? 8'hE0 :
                          model_base(m_sof_total);
         end
         if (hit_req) begin
            m_mask   <= (m_active ? m_mask : 4'b0) | (4'b0001 << hit_side);
            m_left   <= 16;
            m_active <= 1'b1;
            if (!m_active) m_elapsed <= 0;
         end else if (startOfFrame && m_active) begin
            m_left    <= m_left - 1;
            m_elapsed <= m_elapsed + 1;
            if (m_left == 1) begin
               m_active <= 1'b0;
               m_mask   <= 4'b0;
            end
         end
         if (startOfFrame) m_sof_total <= m_sof_total + 1;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en && resetN) begin
         for (int s = 0; s < 4; s++) begin
            cmp($sformatf("model %s_DR", side_name[s]), {7'b0, dut_dr[s]}, {7'b0, exp_dr[s]});
            cmp($sformatf("model %s_RGB", side_name[s]), dut_rgb[s], exp_rgb[s]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(negedge clk);
      hit_req      = 1'b0;
      startOfFrame = 1'b0;
   endtask

   task automatic set_pix(int x, int y);
      pixelX = 11'(x);
      pixelY = 11'(y);
   endtask

   task automatic hit(int side);
      hit_side = 2'(side);
      hit_req  = 1'b1;
      cyc();
   endtask

   task automatic frames(int n);
      for (int i = 0; i < n; i++) begin
         startOfFrame = 1'b1;
         cyc();
      end
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      repeat (2) cyc();
      resetN = 1'b1;
      cyc();
   endtask

   task automatic check_pix_dr(string name, int x, int y, logic [3:0] exp);
      set_pix(x, y);
      cyc();
      cmp(name, {4'b0, dut_dr}, {4'b0, exp});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      set_pix(0, 0);
      repeat (2) cyc();
      check_en = 1'b1;
      cmp("reset top_DR", {7'b0, top_DR}, 8'h00);
      cmp("reset top_RGB", top_RGB, 8'h00);
      resetN = 1'b1;
      cyc();
      cmp("rel top_DR", {7'b0, top_DR}, 8'h01);
      cmp("rel left_DR", {7'b0, left_DR}, 8'h01);
      cmp("rel top_RGB", top_RGB, 8'h92);
      cmp("rel left_RGB", left_RGB, 8'h92);
      cmp("rel right_DR", {7'b0, right_DR}, 8'h00);
      cmp("rel bottom_DR", {7'b0, bottom_DR}, 8'h00);
      cmp("rel right_RGB", right_RGB, 8'h00);
      cmp("rel bottom_RGB", bottom_RGB, 8'h00);

      // Region sweep; DR vector is {bottom,right,left,top}
      check_pix_dr("sweep 320,240", 320, 240, 4'b0000);
      check_pix_dr("sweep 639,479", 639, 479, 4'b1100);
      check_pix_dr("sweep 640,5",   640, 5,   4'b0000);
      check_pix_dr("sweep 7,100",   7,   100, 4'b0010);
      check_pix_dr("sweep 8,100",   8,   100, 4'b0000);
      check_pix_dr("sweep 0,479",   0,   479, 4'b1010);

      // Flash timing on the right side
      do_reset();
      set_pix(635, 100);
      hit(2);
      for (int k = 0; k < 16; k++) begin
         cyc();
         cmp($sformatf("flash frame %0d right_RGB", k), right_RGB,
             (((k / 4) % 2) == 0) ? 8'hE0 : 8'h92);
         frames(1);
      end
      cyc();
      cmp("flash end right_RGB", right_RGB, 8'h92);
      cmp("flash end right_DR", {7'b0, right_DR}, 8'h01);

      // Second hit during a flash
      do_reset();
      set_pix(100, 2);
      hit(0);
      cyc();
      cmp("hit2 top first", top_RGB, 8'hE0);
      frames(10);
      set_pix(100, 475);
      hit(3);
      cyc();
      cmp("hit2 bottom at frame 10", bottom_RGB, 8'hE0);
      frames(15);
      cyc();
      cmp("hit2 bottom before end", bottom_RGB, 8'hE0);
      set_pix(100, 2);
      cyc();
      cmp("hit2 top before end", top_RGB, 8'hE0);
      frames(1);
      cyc();
      cmp("hit2 top after end", top_RGB, 8'h92);

      // Simultaneous hit and frame tick on the last frame
      do_reset();
      set_pix(2, 100);
      hit(1);
      frames(15);
      hit_side     = 2'd1;
      hit_req      = 1'b1;
      startOfFrame = 1'b1;
      cyc();
      cyc();
      cmp("simul left off-phase", left_RGB, 8'h92);
      frames(1);
      cyc();
      cmp("simul still flashing", left_RGB, 8'hE0);
      frames(15);
      cyc();
`ifdef BORDER_COLOR_CYCLE_EN
      cmp("simul exit base", left_RGB, 8'hB7);
`else
      cmp("simul exit base", left_RGB, 8'h92);
`endif

      // Reset in the middle of a flash
      do_reset();
      set_pix(0, 0);
      hit(0);
      frames(2);
      cyc();
      cmp("midrst flashing", top_RGB, 8'hE0);
      #2 resetN = 1'b0;
      #1;
      cmp("midrst top_DR", {7'b0, top_DR}, 8'h00);
      cmp("midrst left_DR", {7'b0, left_DR}, 8'h00);
      cmp("midrst top_RGB", top_RGB, 8'h00);
      cmp("midrst left_RGB", left_RGB, 8'h00);
      hit_req = 1'b1;
      cyc();
      resetN = 1'b1;
      cyc();
      cmp("midrst after release", top_RGB, 8'h92);

`ifdef BORDER_COLOR_CYCLE_EN
      do_reset();
      set_pix(0, 0);
      frames(32);
      cyc();
      cmp("cycle 32 frames", top_RGB, 8'hB7);
      frames(32);
      cyc();
      cmp("cycle 64 frames", top_RGB, 8'hDC);
`endif

      // Randomized traffic checked by the model every cycle
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0:       pixelX = 11'($urandom_range(0, 15));
            1:       pixelX = 11'($urandom_range(625, 645));
            2:       pixelX = 11'($urandom_range(0, 2047));
            default: pixelX = 11'($urandom_range(0, 700));
         endcase
         case ($urandom_range(0, 3))
            0:       pixelY = 11'($urandom_range(0, 15));
            1:       pixelY = 11'($urandom_range(465, 485));
            2:       pixelY = 11'($urandom_range(0, 2047));
            default: pixelY = 11'($urandom_range(0, 520));
         endcase
         hit_side     = 2'($urandom_range(0, 3));
         hit_req      = ($urandom_range(0, 59) == 0);
         startOfFrame = ($urandom_range(0, 5) == 0);
         @(negedge clk);
      end
      hit_req      = 1'b0;
      startOfFrame = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/borders_draw_gen.md
Name: borders_draw_gen

Overview:
- Producer side of the border layer. Generates the four draw-request/colour pairs (top, left, right, bottom) consumed by the border priority mux.
- Decodes the current VGA pixel coordinate into border regions.
- Adds a frame-timed flash effect: a border side blinks after a collision hit on that side.
- Sits between the VGA sync/coordinate generator, the game collision logic, and the border mux.
- All outputs are registered, giving one cycle of latency from the pixel coordinate.

Parameters:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- THICK, 8, border thickness in pixels.
- BORDER_COLOR, 8'h92, idle RGB332 border colour.
- FLASH_COLOR, 8'hE0, RGB332 flash colour (red).
- FLASH_FRAMES, 16, flash duration in frames (1..255).
- BLINK_FRAMES, 4, frames per blink half-period (power of 2, 1..64).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- startOfFrame  in  1  one-cycle pulse at frame start
- hit_req  in  1  one-cycle collision pulse
- hit_side  in  2  side hit: 0 top, 1 left, 2 right, 3 bottom
- top_DR, left_DR, right_DR, bottom_DR  out  1 each  draw requests
- top_RGB, left_RGB, right_RGB, bottom_RGB  out  8 each  side colours

Behaviour:
- Reset: resetN is asynchronous and active-low; clock is clk. While reset is asserted, every DR is 0, every RGB is 8'h00, the state is IDLE, and flash_mask, flash_cnt, blink_cnt and blink_on are all 0. A reset mid-flash aborts the flash immediately.
- Region decode (combinational, then registered):
  - visible = pixelX < SCREEN_W and pixelY < SCREEN_H.
  - top = visible and pixelY < THICK.
  - bottom = visible and pixelY >= SCREEN_H-THICK.
  - left = visible and pixelX < THICK.
  - right = visible and pixelX >= SCREEN_W-THICK.
  - Corners assert two DRs in the same cycle; the mux resolves priority.
- Latency: a DR and its RGB are valid in the cycle after pixelX/pixelY are presented, and the two always update in the same cycle.
- RGB outputs:
  - A side's RGB is 8'h00 whenever its DR is 0.
  - When its DR is 1, the side uses FLASH_COLOR if its flash_mask bit is set and blink_on=1; otherwise it uses the base colour.
- State machine, states IDLE and FLASH:
  - IDLE, hit_req=1: go to FLASH. Set flash_mask[hit_side], flash_cnt=FLASH_FRAMES, blink_cnt=0, blink_on=1.
  - FLASH, hit_req=1: OR the new side into flash_mask and reload flash_cnt=FLASH_FRAMES. blink_on and blink_cnt are unchanged.
  - FLASH, startOfFrame=1 (no hit): decrement flash_cnt and increment blink_cnt. When blink_cnt wraps at BLINK_FRAMES, toggle blink_on. If flash_cnt was 1, go to IDLE and clear flash_mask and blink_on.
  - hit_req and startOfFrame in the same cycle: the hit wins. The counter reloads and no decrement happens that cycle.
  - hit_req while resetN=0 is ignored.
- Arithmetic: flash_cnt is 8 bits and blink_cnt is 6 bits, both unsigned. Neither counter ever underflows, because the exit happens at a value of 1.

Optional Feature:
- Macro: BORDER_COLOR_CYCLE_EN.
- Defined: the base colour is a register, reset to BORDER_COLOR. On every 32nd startOfFrame it increments by 8'h25, modulo 256, via a 5-bit frame counter that resets to 0. The cycling is independent of the flash state.
- Undefined: the base colour is the constant BORDER_COLOR, and no extra registers exist.

Decomposition:
- Package borders_pkg:
  - enum side_t (SIDE_TOP=0, SIDE_LEFT=1, SIDE_RIGHT=2, SIDE_BOTTOM=3);
  - enum flash_state_t (IDLE, FLASH);
  - default colour constants;
  - the 11-bit coordinate width constant.
- One sub-module: border_flash_timer. It holds the FSM, flash_cnt, blink_cnt, blink_on and flash_mask, and outputs a 4-bit flash_active vector. The top level holds the region decode and output registers.

Test Plan:
- Reset checks:
  - Reset release, pixel (0,0): the cycle after, top_DR=1, left_DR=1, both RGB=8'h92; right_DR=0, bottom_DR=0, their RGB=8'h00.
  - Pulse resetN low mid-flash: all outputs 0 at once. After release, pixel (0,0) shows top_RGB=8'h92.
- Region sweep:
  - Pixel (320,240): all DR=0.
  - Pixel (639,479): right and bottom DR=1.
  - Pixel (640,5): all DR=0.
  - Pixel (7,100): left only.
  - Pixel (8,100): none.
- Flash timing: hit_req with hit_side=2, then 16 startOfFrame pulses at pixel (635,100):
  - right_RGB = 8'hE0 for frames 0-3, 8'h92 for frames 4-7, 8'hE0 for frames 8-11, 8'h92 for frames 12-15.
  - After the 16th pulse: IDLE, colour 8'h92.
- Second hit during a flash: hit side 0, then hit side 3 at frame 10. Both top and bottom flash, and the flash ends 16 frames after the second hit.
- Simultaneous hit_req and startOfFrame when flash_cnt=1: the block stays in FLASH and flash_cnt=16.
- With BORDER_COLOR_CYCLE_EN defined: after 32 startOfFrame pulses the base colour is 8'hB7; after 64 pulses it is 8'hDC.
